// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM front end: per-microphone N-order CIC integrators in the sclk event domain,
// followed by a shared comb pipeline that carries each decimated sample with its channel tag.

module pdm_cic_chan #(
  parameter int N     = 4,
  parameter int D     = 6,
  parameter int ACC_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             evt,
  input  logic             pdm,
  output logic             dump,
  output logic             settled,
  output logic [ACC_W-1:0] last
);
  logic [N-1:0][ACC_W-1:0] integ, integ_nxt;
  logic [D-1:0]            cnt;
  logic [2:0]              settle;

  // Integrators chain on next-values so the dumped sum includes the current bit.
  always_comb begin
    integ_nxt    = integ;
    integ_nxt[0] = integ[0] + {{(ACC_W-1){~pdm}}, 1'b1};
    for (int k = 1; k < N; k++)
      integ_nxt[k] = integ[k] + integ_nxt[k-1];
  end

  assign dump    = evt & (cnt == '1);
  assign settled = (settle == 3'(N));
  assign last    = integ_nxt[N-1];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      integ  <= '0;
      cnt    <= '0;
      settle <= '0;
    end else if (evt) begin
      integ <= integ_nxt;
      cnt   <= cnt + 1'b1;
      if (dump && !settled) settle <= settle + 3'd1;
    end
  end
endmodule

module pdm_cic_decimator #(
  parameter int CHANNELS   = 1,
  parameter int CIC_ORDER  = 4,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sclk,
  input  logic             dat_i,
  output logic             dv,
  output logic             dch,
  output logic [OUT_W-1:0] dat_o
);
  localparam int ACC_W = CIC_ORDER*DECIM_LOG2 + 2;
  localparam int SHIFT = CIC_ORDER*DECIM_LOG2 + 1 - OUT_W;
  localparam int N     = CIC_ORDER;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0] sclk_sync, dat_sync;
  logic       sclk_d, rise, fall;
  logic [CHANNELS-1:0] evt, dump, settled;
  logic [CHANNELS-1:0][ACC_W-1:0] last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      dat_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      dat_sync  <= {dat_sync[0], dat_i};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign rise = sclk_sync[1] & ~sclk_d;
  assign fall = ~sclk_sync[1] & sclk_d;

  always_comb begin
    evt    = '0;
    evt[0] = rise;
    if (CHANNELS > 1) evt[CHANNELS-1] = fall;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pdm_cic_chan #(.N(N), .D(DECIM_LOG2), .ACC_W(ACC_W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .clr     (~en),
      .evt     (evt[c]),
      .pdm     (dat_sync[1]),
      .dump    (dump[c]),
      .settled (settled[c]),
      .last    (last[c])
    );
  end

  // Rise and fall events never coincide, so at most one channel dumps per cycle.
  logic             cap_vld, cap_ch, cap_keep;
  logic [ACC_W-1:0] cap_val;

  always_comb begin
    cap_vld  = |dump;
    cap_ch   = 1'b0;
    cap_val  = last[0];
    cap_keep = settled[0];
    if (CHANNELS > 1 && dump[CHANNELS-1]) begin
      cap_ch   = 1'b1;
      cap_val  = last[CHANNELS-1];
      cap_keep = settled[CHANNELS-1];
    end
  end

  logic [N:0]                   vld_pipe, tag_pipe, keep_pipe;
  logic [N:0][ACC_W-1:0]        dat_pipe;
  logic [CHANNELS-1:0][N-1:0][ACC_W-1:0] dly;
  logic signed [ACC_W-1:0]      shifted;
  logic [OUT_W-1:0]             sat;

  always_comb begin
    shifted = $signed(dat_pipe[N]) >>> SHIFT;
    if (shifted > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) sat = SAT_LO[OUT_W-1:0];
    else                       sat = shifted[OUT_W-1:0];
  end

  // Suppressed (unsettled) samples still flow through the combs to prime the delay regs.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      keep_pipe <= '0;
      dat_pipe  <= '0;
      dly       <= '0;
      dv        <= 1'b0;
      if (reset) begin
        dch   <= 1'b0;
        dat_o <= '0;
      end
    end else begin
      vld_pipe    <= {vld_pipe[N-1:0], cap_vld};
      tag_pipe    <= {tag_pipe[N-1:0], cap_ch};
      keep_pipe   <= {keep_pipe[N-1:0], cap_keep};
      dat_pipe[0] <= cap_val;
      for (int k = 1; k <= N; k++) begin
        dat_pipe[k] <= dat_pipe[k-1] - dly[tag_pipe[k-1]][k-1];
        if (vld_pipe[k-1]) dly[tag_pipe[k-1]][k-1] <= dat_pipe[k-1];
      end
      dv <= vld_pipe[N] & keep_pipe[N];
      if (vld_pipe[N] && keep_pipe[N]) begin
        dch   <= tag_pipe[N];
        dat_o <= sat;
      end
    end
  end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Stereo PDM decimator bench: random/constant/pattern bit streams checked against a
// direct FIR (boxcar^N) model of the CIC, plus settle, latency, reset and enable behaviour.

module tb_pdm_cic_decimator;
  localparam int N     = 4;
  localparam int D     = 6;
  localparam int R     = 64;
  localparam int OUT_W = 16;
  localparam int SHIFT = N*D + 1 - OUT_W;
  localparam int HLEN  = N*(R-1) + 1;
  localparam longint LAT = (N+4)*10 + 4;

  logic clk, reset, en, sclk, dat_i;
  logic dv, dch;
  logic [OUT_W-1:0] dat_o;

  pdm_cic_decimator #(.CHANNELS(2), .CIC_ORDER(N), .DECIM_LOG2(D), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .sclk  (sclk),
    .dat_i (dat_i),
    .dv    (dv),
    .dch   (dch),
    .dat_o (dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint val;
    longint t;
  } exp_t;

  int     n_vec = 0, n_err = 0, n_dv = 0, n_exp = 0;
  longint h [0:HLEN-1];
  int     xs0[$], xs1[$];
  exp_t   q0[$], q1[$];
  longint last_out = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Impulse response of N cascaded length-R moving sums.
  task automatic build_h();
    longint cur[0:HLEN-1], nxt[0:HLEN-1];
    int len = 1;
    for (int i = 0; i < HLEN; i++) cur[i] = 0;
    cur[0] = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HLEN; i++) begin
        nxt[i] = 0;
        for (int j = 0; j < R; j++)
          if (i-j >= 0 && i-j < len) nxt[i] += cur[i-j];
      end
      len += R-1;
      for (int i = 0; i < HLEN; i++) cur[i] = nxt[i];
    end
    for (int i = 0; i < HLEN; i++) h[i] = cur[i];
  endtask

  function automatic longint cic_out(input int c);
    longint acc = 0;
    int n, idx, x;
    n = (c == 0) ? xs0.size() : xs1.size();
    for (int j = 0; j < HLEN; j++) begin
      idx = n - 1 - j;
      if (idx >= 0) begin
        x = (c == 0) ? xs0[idx] : xs1[idx];
        acc += h[j] * x;
      end
    end
    acc = acc >>> SHIFT;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic model_bit(input int c, input bit b);
    exp_t e;
    int n;
    if (c == 0) xs0.push_back(b ? 1 : -1);
    else        xs1.push_back(b ? 1 : -1);
    n = (c == 0) ? xs0.size() : xs1.size();
    if (n % R == 0 && n / R > N) begin
      e.val = cic_out(c);
      e.t   = longint'($time);
      if (c == 0) q0.push_back(e);
      else        q1.push_back(e);
      n_exp++;
    end
  endtask

  task automatic model_clear();
    xs0.delete(); xs1.delete();
    q0.delete();  q1.delete();
  endtask

  // One sclk period = 8 clk: ch0 bit presented before the rise, ch1 bit before the fall.
  task automatic drive_period(input bit b0, input bit b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      case (k)
        0: dat_i = b0;
        2: begin sclk = 1'b1; model_bit(0, b0); end
        4: dat_i = b1;
        6: begin sclk = 1'b0; model_bit(1, b1); end
        default: ;
      endcase
    end
  endtask

  task automatic drive_random(input int periods);
    int p0, p1;
    for (int i = 0; i < periods; i++) begin
      if (i % R == 0) begin
        p0 = $urandom_range(5, 95);
        p1 = $urandom_range(5, 95);
      end
      drive_period($urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (dv) begin
      have = 1'b0;
      if (dch == 1'b0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      else if (dch == 1'b1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) chk("dv_unexpected", longint'(dv), 0);
      else begin
        n_dv++;
        chk(dch ? "dat_o_ch1" : "dat_o_ch0", longint'($signed(dat_o)), e.val);
        chk("latency", longint'($time) - e.t, LAT);
        last_out = e.val;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; sclk = 1'b0; dat_i = 1'b0;
    build_h();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_dv", longint'(dv), 0);
    chk("reset_dch", longint'(dch), 0);
    chk("reset_dat_o", longint'($signed(dat_o)), 0);
    @(posedge clk); #1 reset = 1'b0;

    drive_random(14*R);

    // Constant streams: ch0 full-scale positive, ch1 full-scale negative.
    for (int i = 0; i < 7*R; i++) drive_period(1'b1, 1'b0);

    // ch0 alternating 1,0 -> 0; ch1 1,0,0,0 -> -R^N/2.
    for (int i = 0; i < 7*R; i++) drive_period(i % 2 == 0, i % 4 == 0);

    // Enable dropped mid-frame: no output, dat_o holds, then settle restarts.
    drive_random(30);
    @(posedge clk); #1 en = 1'b0;
    model_clear();
    repeat (10) begin
      @(negedge clk);
      chk("en_low_dv", longint'(dv), 0);
    end
    chk("en_low_hold", longint'($signed(dat_o)), last_out);
    @(posedge clk); #1 en = 1'b1;
    drive_random(6*R);

    // Reset pulse mid-frame.
    drive_random(30);
    @(posedge clk); #1 reset = 1'b1;
    model_clear();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_dv", longint'(dv), 0);
    chk("midreset_dch", longint'(dch), 0);
    chk("midreset_dat_o", longint'($signed(dat_o)), 0);
    drive_random(6*R);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pending_ch0", longint'(q0.size()), 0);
    chk("pending_ch1", longint'(q1.size()), 0);
    chk("dv_count", longint'(n_dv), longint'(n_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
Parametrised successor to the single-mic PDM front end: converts a 1-bit PDM stream from one or two MEMS microphones (stereo pair sharing sclk/dat_i) into signed PCM samples with an N-order CIC decimator. Sits between the microphone pins and the MFCC/DNN feature pipeline. Runs entirely in the system clk domain; sclk and dat_i are asynchronous inputs.

Parameters:
CHANNELS, 1, number of microphones (1 or 2); ch0 sampled on sclk rising edge, ch1 on falling edge
CIC_ORDER, 4, CIC order N (1..6)
DECIM_LOG2, 6, log2 of decimation ratio R (R = 64 -> 31.25 kHz at 2 MHz sclk)
OUT_W, 16, output sample width; requires N*DECIM_LOG2+1 >= OUT_W

Ports:
clk  in  1  system clock; must be >= 4x sclk frequency
reset  in  1  synchronous, active-high reset
en  in  1  filter enable; low holds filter state cleared
sclk  in  1  PDM bit clock (generated externally), asynchronous
dat_i  in  1  PDM data, asynchronous
dv  out  1  one-clk pulse, dat_o/dch valid
dch  out  1  channel of current sample (always 0 when CHANNELS=1)
dat_o  out  OUT_W  signed PCM sample

Behaviour:
- Reset: dv=0, dch=0, dat_o=0; integrators, comb delays, decimation counters, settle counters all 0. Synchronisers also cleared.
- Input sync: sclk and dat_i each pass through a 2-flop synchroniser; sclk edge detected from synchronised value. Edge-detect cycle = t. Rising edge -> ch0 sample event; falling edge -> ch1 event (ignored when CHANNELS=1).
- Bit mapping: 1 -> +1, 0 -> -1. Internal width ACC_W = N*DECIM_LOG2+2, two's complement, integrators wrap modulo 2^ACC_W (intended; comb cancels wrap).
- Per channel: N cascaded integrators updated at cycle t; decimation counter (DECIM_LOG2 bits) increments per event, wraps at R-1 -> 0.
- On the event where counter = R-1: last integrator value captured at t+1 with channel tag; comb stage k (y = x - x_prev, per-channel delay reg) registered at t+1+k, k=1..N; output stage at t+N+2.
- Output stage: s = comb_out >>> SHIFT, SHIFT = N*DECIM_LOG2+1-OUT_W; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (only +full-scale +R^N saturates). dv=1 for exactly one cycle at t+N+2; dat_o/dch held until next dv.
- Settle: per channel, first N decimated outputs after reset or en rising are computed but suppressed (dv stays 0); output N+1 onward asserted.
- Channels never collide in the comb pipeline (events >= 2 clk apart; pipeline carries tag); comb delay regs per channel.
- en low: same clearing as reset except synchronisers keep running and dat_o holds last value; in-flight pipeline entries discarded (no dv while en=0 or after its falling edge).
- reset asserted mid-decimation: all state cleared next cycle, in-flight sample dropped; counting restarts from 0 at first event after release.
- Mono/stereo difference only in falling-edge handling and per-channel state instantiation.

Test Plan:
- Defaults, CHANNELS=1, dat_i=1 constant, sclk 2 MHz, clk 50 MHz -> first 4 decimated outputs suppressed, then dv every 64 sclk periods, dat_o=32767 (saturated).
- dat_i=0 constant -> dat_o=-32768 after settle, no saturation flag behaviour differences, dch=0.
- dat_i pattern 1,0 alternating per sclk rising edge -> settled dat_o=0 exactly; pattern 1,0,0,0 -> dat_o=-16384.
- CHANNELS=2, dat_i=1 during sclk high-phase samples, 0 at falling-edge samples -> alternating dv with dch=0 value 32767 and dch=1 value -32768; each channel dv spaced 64 sclk periods.
- Latency check: dv asserted exactly N+2=6 clk after the detected 64th rising edge (cycle-counted from synchronised edge).
- Reset pulse at 30th bit of a frame, then en toggled low 10 cycles -> dv=0 throughout, counter restarts, 4 outputs suppressed again, 5th output at 5*64 sclk periods after restart.
